// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// icache_if : fetch-side and memory-side signal bundle of the instruction cache
// Revision  : 1.0
// ============================================================================
interface icache_if;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        mem_req;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  // The cache itself: answers fetches, issues line-refill word requests.
  modport slave (
    input  fetch_addr, mem_resp_valid, mem_resp_data,
    output fetch_valid, fetch_instr, mem_req, mem_req_addr
  );

  // Fetcher plus memory controller as seen from the cache.
  modport master (
    output fetch_addr, mem_resp_valid, mem_resp_data,
    input  fetch_valid, fetch_instr, mem_req, mem_req_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// icache   : direct-mapped read-only instruction cache, 4-word lines,
//            combinational hit path, word-serial line refill
// Revision : 1.0
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][4];

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [27:0] base_q, base_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;

  logic                  fill_start;
  logic                  word_we;
  logic                  line_done;
  logic [1:0]            off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic                  hit;
  logic                  unused_byte_sel;

  assign off      = bus.fetch_addr[3:2];
  assign idx      = bus.fetch_addr[INDEX_BITS+3:4];
  assign tag      = bus.fetch_addr[31:INDEX_BITS+4];
  assign fill_idx = base_q[INDEX_BITS-1:0];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  assign unused_byte_sel = ^bus.fetch_addr[1:0];

  assign bus.fetch_valid  = hit;
  assign bus.fetch_instr  = data_q[idx][off];
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_req_addr = mem_req_addr_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    base_d         = base_q;
    mem_req_d      = mem_req_q;
    mem_req_addr_d = mem_req_addr_q;
    fill_start     = 1'b0;
    word_we        = 1'b0;
    line_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          fill_start     = 1'b1;
          base_d         = bus.fetch_addr[31:4];
          cnt_d          = 2'd0;
          mem_req_d      = 1'b1;
          mem_req_addr_d = {bus.fetch_addr[31:4], 4'b0000};
          state_d        = FILL;
        end
      end
      FILL: begin
        if (bus.mem_resp_valid) begin
          word_we = 1'b1;
          if (cnt_q == 2'd3) begin
            line_done = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            cnt_d          = cnt_q + 2'd1;
            mem_req_addr_d = {base_q, cnt_d, 2'b00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 2'd0;
      base_q         <= 28'd0;
      mem_req_q      <= 1'b0;
      mem_req_addr_q <= 32'd0;
    end else if (rdy) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      base_q         <= base_d;
      mem_req_q      <= mem_req_d;
      mem_req_addr_q <= mem_req_addr_d;
    end
  end

  // The line being refilled is invalidated up front so it never hits on stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy) begin
      if (fill_start) valid_q[idx]      <= 1'b0;
      if (line_done)  valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (word_we)   data_q[fill_idx][cnt_q] <= bus.mem_resp_data;
      if (line_done) tag_q[fill_idx]         <= base_q[27:INDEX_BITS];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// tb_icache : self-checking bench for icache (directed sequences, vector
//             table, random traffic against a line-level reference model)
// Revision  : 1.0
// ============================================================================
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  icache_if ifc ();

  icache #(.INDEX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          resp_lat   = 1;
  int          resp_wait  = 0;
  int          stray_req  = 0;
  int          stray_seen = 0;
  logic [31:0] resp_log [$];

  typedef struct {
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_hit(input string name, input int max);
    int n = 0;
    @(negedge clk);
    while (!ifc.fetch_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk1(name, ifc.fetch_valid, 1'b1);
  endtask

  task automatic wait_log(input string name, input int target, input int max);
    int n = 0;
    @(negedge clk);
    while (resp_log.size() < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk1(name, resp_log.size() >= target, 1'b1);
  endtask

  // Memory controller: answers each pending word after resp_lat idle cycles.
  initial begin
    ifc.mem_resp_valid = 1'b0;
    ifc.mem_resp_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      ifc.mem_resp_valid = 1'b0;
      if (stray_req != stray_seen) begin
        ifc.mem_resp_valid = 1'b1;
        ifc.mem_resp_data  = 32'hDEAD_BEEF;
        stray_seen         = stray_req;
      end else if (!ifc.mem_req) begin
        resp_wait = resp_lat;
      end else if (resp_wait > 0) begin
        resp_wait--;
      end else begin
        ifc.mem_resp_valid = 1'b1;
        ifc.mem_resp_data  = mem_word(ifc.mem_req_addr);
        resp_log.push_back(ifc.mem_req_addr);
        resp_wait = resp_lat;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] pool [8];
    bit   [63:0] mv;
    logic [21:0] mt [64];
    bit          m_fill;
    int          m_cnt;
    logic [31:0] m_base;
    logic [31:0] a;
    bit          exp_hit;
    int          base;
    int          n;

    vecs[0]  = '{32'h0000_0100, 1'b1, mem_word(32'h100)};
    vecs[1]  = '{32'h0000_0104, 1'b1, mem_word(32'h104)};
    vecs[2]  = '{32'h0000_0108, 1'b1, mem_word(32'h108)};
    vecs[3]  = '{32'h0000_010C, 1'b1, mem_word(32'h10C)};
    vecs[4]  = '{32'h0000_0080, 1'b1, mem_word(32'h080)};
    vecs[5]  = '{32'h0000_008C, 1'b1, mem_word(32'h08C)};
    vecs[6]  = '{32'h0000_0102, 1'b1, mem_word(32'h100)};
    vecs[7]  = '{32'h0000_008F, 1'b1, mem_word(32'h08C)};
    vecs[8]  = '{32'h0000_0500, 1'b0, 32'd0};
    vecs[9]  = '{32'h0000_0480, 1'b0, 32'd0};
    vecs[10] = '{32'h0000_0000, 1'b0, 32'd0};
    vecs[11] = '{32'h0000_0200, 1'b0, 32'd0};
    pool = '{32'h0, 32'h400, 32'h800, 32'h10, 32'h410, 32'h20, 32'h3F0, 32'hABCD_E3F0};

    // Reset and first fill with cycle-exact request stepping
    rst = 1'b1;
    rdy = 1'b1;
    ifc.fetch_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("reset_valid", ifc.fetch_valid, 1'b0);
    chk1("reset_req", ifc.mem_req, 1'b0);
    chk("reset_req_addr", ifc.mem_req_addr, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk1("fill0_req", ifc.mem_req, 1'b1);
      chk("fill0_req_addr", ifc.mem_req_addr, 32'(4 * ((c - 1) / 2)));
      chk1("fill0_not_valid", ifc.fetch_valid, 1'b0);
    end
    @(negedge clk);
    chk1("fill0_hit_at_9", ifc.fetch_valid, 1'b1);
    chk("fill0_word0", ifc.fetch_instr, 32'h11);
    chk1("fill0_req_drop", ifc.mem_req, 1'b0);
    @(posedge clk); #1 ifc.fetch_addr = 32'hC;
    @(negedge clk);
    chk1("hit_c_valid", ifc.fetch_valid, 1'b1);
    chk("hit_c_word", ifc.fetch_instr, 32'h44);
    @(negedge clk);
    chk1("hit_c_no_req", ifc.mem_req, 1'b0);

    // Conflict eviction: 0x400 replaces 0x000, which then refetches
    @(posedge clk); #1 ifc.fetch_addr = 32'h400;
    wait_hit("fill400_done", 40);
    chk("fill400_word", ifc.fetch_instr, mem_word(32'h400));
    base = resp_log.size();
    @(posedge clk); #1 ifc.fetch_addr = 32'h0;
    @(negedge clk);
    chk1("conflict_miss", ifc.fetch_valid, 1'b0);
    wait_hit("refill0_done", 40);
    chk("refill0_word", ifc.fetch_instr, 32'h11);
    chk("refill0_count", 32'(resp_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) chk("refill0_addr", resp_log[base + k], 32'(4 * k));

    // Hit-under-fill with a slow responder
    @(posedge clk); #1 ifc.fetch_addr = 32'h10;
    wait_hit("fill10_done", 40);
    resp_lat = 3;
    @(posedge clk); #1 ifc.fetch_addr = 32'h40;
    @(posedge clk); #1 ifc.fetch_addr = 32'h14;
    @(negedge clk);
    chk1("huf_valid", ifc.fetch_valid, 1'b1);
    chk("huf_word", ifc.fetch_instr, mem_word(32'h14));
    chk1("huf_req_held", ifc.mem_req, 1'b1);
    chk("huf_req_addr", ifc.mem_req_addr, 32'h40);
    @(posedge clk); #1 ifc.fetch_addr = 32'h44;
    @(negedge clk);
    chk1("huf_filling_line_invalid", ifc.fetch_valid, 1'b0);
    @(posedge clk); #1 ifc.fetch_addr = 32'h40;
    wait_hit("fill40_done", 60);
    chk("fill40_word", ifc.fetch_instr, mem_word(32'h40));
    resp_lat = 1;

    // Fetch address change mid-fill does not abort the line
    base = resp_log.size();
    @(posedge clk); #1 ifc.fetch_addr = 32'h80;
    wait_log("redirect_two_resp", base + 2, 40);
    @(posedge clk); #1 ifc.fetch_addr = 32'h200;
    wait_hit("fill200_done", 60);
    chk("fill200_word", ifc.fetch_instr, mem_word(32'h200));
    chk("redirect_count", 32'(resp_log.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) begin
      chk("redirect_addr_80", resp_log[base + k], 32'h80 + 32'(4 * k));
      chk("redirect_addr_200", resp_log[base + 4 + k], 32'h200 + 32'(4 * k));
    end
    @(posedge clk); #1 ifc.fetch_addr = 32'h80;
    @(negedge clk);
    chk1("line80_valid", ifc.fetch_valid, 1'b1);
    chk("line80_word", ifc.fetch_instr, mem_word(32'h80));

    // Reset mid-fill followed by a stray response
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    base = resp_log.size();
    @(posedge clk); #1 rst = 1'b0;
    wait_log("rstfill_two_resp", base + 2, 40);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    stray_req++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_mid_req", ifc.mem_req, 1'b0);
    chk1("rst_mid_80_miss", ifc.fetch_valid, 1'b0);
    chk1("stray_present", ifc.mem_resp_valid, 1'b1);
    base = resp_log.size();
    @(negedge clk);
    chk1("after_stray_req", ifc.mem_req, 1'b1);
    chk("after_stray_req_addr", ifc.mem_req_addr, 32'h80);
    wait_hit("after_stray_fill", 40);
    chk("after_stray_word", ifc.fetch_instr, mem_word(32'h80));
    chk("after_stray_count", 32'(resp_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) chk("after_stray_addr", resp_log[base + k], 32'h80 + 32'(4 * k));

    // rdy low stalls the fill even while responses arrive
    resp_lat = 0;
    @(posedge clk); #1 ifc.fetch_addr = 32'h100;
    n = 0;
    @(negedge clk);
    while (ifc.mem_req_addr != 32'h104 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_104", ifc.mem_req_addr, 32'h104);
    @(posedge clk); #1 rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_req_addr", ifc.mem_req_addr, 32'h108);
      chk1("stall_req", ifc.mem_req, 1'b1);
      chk1("stall_resp_pulsed", ifc.mem_resp_valid, 1'b1);
      if (s < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1 rdy = 1'b1;
    wait_hit("stall_fill_done", 40);
    resp_lat = 1;

    // Vector table: pure lookups with the cache frozen
    @(posedge clk); #1 rdy = 1'b0;
    for (int v = 0; v < 12; v++) begin
      ifc.fetch_addr = vecs[v].addr;
      @(negedge clk);
      chk1("vec_valid", ifc.fetch_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) chk("vec_instr", ifc.fetch_instr, vecs[v].exp_instr);
      chk1("vec_no_req", ifc.mem_req, 1'b0);
      @(posedge clk); #1;
    end

    // Random traffic against a line-level model
    rdy = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mv     = '0;
    m_fill = 1'b0;
    m_cnt  = 0;
    m_base = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0)
        ifc.fetch_addr = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      if (i % 64 == 0) resp_lat = $urandom_range(0, 3);
      a       = ifc.fetch_addr;
      exp_hit = mv[a[9:4]] && (mt[a[9:4]] == a[31:10]);
      chk1("rnd_valid", ifc.fetch_valid, exp_hit);
      if (exp_hit) chk("rnd_instr", ifc.fetch_instr, mem_word({a[31:2], 2'b00}));
      chk1("rnd_req", ifc.mem_req, m_fill);
      if (m_fill) chk("rnd_req_addr", ifc.mem_req_addr, m_base + 32'(4 * m_cnt));
      if (rdy) begin
        if (!m_fill) begin
          if (!exp_hit) begin
            m_fill       = 1'b1;
            m_base       = {a[31:4], 4'b0000};
            m_cnt        = 0;
            mv[a[9:4]]   = 1'b0;
          end
        end else if (ifc.mem_resp_valid) begin
          m_cnt++;
          if (m_cnt == 4) begin
            mv[m_base[9:4]] = 1'b1;
            mt[m_base[9:4]] = m_base[31:10];
            m_fill          = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache: the responder end of the fetch-address/instruction-word protocol driven by the instruction fetcher. It answers the fetcher's word address combinationally on a hit. On a miss it refills a 16-byte line from the memory controller through a word-wide request/response handshake. It sits between the instruction fetcher and the memory controller's instruction port.

## Interface
- INDEX_BITS, 6: line index width; the cache holds 2^INDEX_BITS lines of 4 words (16 B) each.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, no state changes at all.
- fetch_addr  in  32  byte address of the requested instruction; bits [1:0] ignored.
- fetch_valid  out  1  combinational; high when fetch_addr hits a valid line.
- fetch_instr  out  32  combinational; word at fetch_addr when fetch_valid=1, don't-care otherwise.
- mem_req  out  1  registered; a word read request is pending.
- mem_req_addr  out  32  registered; word-aligned address of the pending request.
- mem_resp_valid  in  1  one-cycle pulse; the pending request is answered.
- mem_resp_data  in  32  word returned with mem_resp_valid.

## Operation
- Address split: offset = fetch_addr[3:2], index = fetch_addr[INDEX_BITS+3:4], tag = fetch_addr[31:INDEX_BITS+4].
- Storage: per line, a valid bit, a tag, and 4 data words. Read is asynchronous: fetch_valid = valid[index] && tag[index]==tag; fetch_instr = data[index][offset].
- FSM states: IDLE, FILL.
- IDLE, fetch_valid=0: at the edge, latch line_base = {fetch_addr[31:4],4'b0}, clear valid[index], set word counter cnt=0, mem_req=1, mem_req_addr=line_base, and go to FILL.
- IDLE, fetch_valid=1: no action.
- FILL: mem_req stays high and mem_req_addr = line_base + 4*cnt.
- FILL, mem_resp_valid=1: write mem_resp_data into data[line index][cnt].
  - If cnt<3: cnt+1, and mem_req_addr advances on the same edge.
  - If cnt=3: set valid and tag for the line, mem_req=0, go to IDLE.
- Hit-under-fill: hits on other lines are served normally during FILL. The line being filled reads invalid until its fill completes.
- A change of fetch_addr during FILL, e.g. after a fetcher flush, does not abort the fill. The line completes; the new address is evaluated in IDLE afterwards.
- mem_resp_valid outside FILL is ignored.

## Timing
- Reset values:
  - All valid bits 0, so fetch_valid=0 for any address.
  - mem_req=0, mem_req_addr=0, state IDLE, cnt=0.
  - Data and tag arrays are not reset.
- Hit latency: 0 cycles (combinational from fetch_addr).
- Miss: mem_req rises at the edge following the first cycle the miss is seen in IDLE.
- Handshake: one response per request. The memory controller responds no earlier than the cycle after mem_req/mem_req_addr change. mem_req is never dropped mid-line.
- Fill completion: fetch_valid for the filled address rises in the cycle after the 4th mem_resp_valid edge.
- With a 1-cycle responder, miss-to-hit is 1 + 4×2 = 9 cycles.
- The fill returns to IDLE for one cycle minimum. A back-to-back miss starts a new fill on the following edge.
- rst mid-fill: immediate return to IDLE with mem_req=0. Any later response is ignored.
- rdy=0: FSM, counter, arrays and mem_req* hold. Combinational outputs still track fetch_addr.

## Test plan
- Reset, then fetch_addr=0x0: fetch_valid=0 and mem_req rises next edge with mem_req_addr=0x0. Responder returns 0x11,0x22,0x33,0x44 for 0x0,0x4,0x8,0xC; mem_req_addr steps by 4 after each response. After the 4th, fetch_valid=1 and fetch_instr=0x11. fetch_addr=0xC then gives 0x44 with no new request.
- Conflict: fill 0x000 then 0x400 (same index with INDEX_BITS=6). fetch_addr=0x000 misses again and refetches 0x000–0x00C.
- Hit-under-fill: line 0x10 is valid and a fill of 0x40 is pending. fetch_addr=0x14 gives fetch_valid=1 with the stored word, and mem_req remains high.
- Address change mid-fill (0x80 → 0x200 after 2 responses): the fill continues to 0x8C. Then a new fill starts at 0x200. Line 0x80 ends valid.
- rst asserted after 2 responses: mem_req=0 next edge. A stray mem_resp_valid is ignored, and a later fetch of 0x80 misses.
- rdy=0 for 3 cycles during FILL with mem_resp_valid pulsed: cnt and mem_req_addr unchanged. Normal fill resumes when rdy=1.
